// File: rtl/midi_pkg.sv
// rtl/midi_pkg.sv - shared MIDI constants, command encoding and FSM state types
package midi_pkg;

    // Status nibbles / bytes, shared with the receive FSM
    localparam logic [3:0] NOTE_OFF = 4'h8;
    localparam logic [3:0] NOTE_ON  = 4'h9;
    localparam logic [3:0] PROGRAM  = 4'hC;
    localparam logic [7:0] RESET    = 8'hFF;

    // A value no real status byte can take; marks "no status remembered"
    localparam logic [7:0] STATUS_NONE = 8'h00;

    // cmd input encoding
    localparam logic [1:0] CMD_NOTE_OFF = 2'd0;
    localparam logic [1:0] CMD_NOTE_ON  = 2'd1;
    localparam logic [1:0] CMD_PROGRAM  = 2'd2;
    localparam logic [1:0] CMD_RESET    = 2'd3;

    typedef enum logic [1:0] {
        MSG_IDLE,
        MSG_LOAD,
        MSG_SEND,
        MSG_NEXT
    } msg_state_e;

    typedef enum logic [1:0] {
        UART_IDLE,
        UART_START,
        UART_DATA,
        UART_STOP
    } uart_state_e;

    function automatic logic [7:0] status_byte(input logic [1:0] cmd, input logic [3:0] channel);
        case (cmd)
            CMD_NOTE_OFF: return {NOTE_OFF, channel};
            CMD_NOTE_ON:  return {NOTE_ON, channel};
            CMD_PROGRAM:  return {PROGRAM, channel};
            default:      return RESET;
        endcase
    endfunction

    // Index of the final byte of a message: notes 3 bytes, program 2, reset 1
    function automatic logic [1:0] last_byte_idx(input logic [1:0] cmd);
        case (cmd)
            CMD_NOTE_OFF, CMD_NOTE_ON: return 2'd2;
            CMD_PROGRAM:               return 2'd1;
            default:                   return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/midi_uart_tx.sv
// rtl/midi_uart_tx.sv - byte-in/bit-out 8N1 serializer
module midi_uart_tx
    import midi_pkg::*;
#(
    parameter int BAUD_DIV = 1600
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       ce,
    input  logic [7:0] data,
    input  logic       start,
    output logic       busy,
    output logic       tx
);

    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] LAST_TICK = CW'(BAUD_DIV - 1);

    uart_state_e   state;
    uart_state_e   state_next;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          bit_end;

    assign bit_end = ce && (baud_cnt == LAST_TICK);

    // State register, baud counter, bit index and shift register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= UART_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
        end else if (ce) begin
            state <= state_next;
            if (state == UART_IDLE) begin
                baud_cnt <= '0;
                bit_idx  <= '0;
                if (start) begin
                    shreg <= data;
                end
            end else begin
                baud_cnt <= bit_end ? '0 : baud_cnt + CW'(1);
                if (state == UART_DATA && bit_end) begin
                    shreg   <= {1'b0, shreg[7:1]};
                    bit_idx <= bit_idx + 3'd1;
                end
            end
        end
    end

    // Next state and line drive; busy drops in the final stop-bit cycle so the
    // message FSM can line up the next byte with minimal idle gap
    always_comb begin
        state_next = state;
        tx         = 1'b1;
        busy       = 1'b1;
        case (state)
            UART_IDLE: begin
                busy = 1'b0;
                if (ce && start) begin
                    state_next = UART_START;
                end
            end
            UART_START: begin
                tx = 1'b0;
                if (bit_end) begin
                    state_next = UART_DATA;
                end
            end
            UART_DATA: begin
                tx = shreg[0];
                if (bit_end && bit_idx == 3'd7) begin
                    state_next = UART_STOP;
                end
            end
            UART_STOP: begin
                busy = !bit_end;
                if (bit_end) begin
                    state_next = UART_IDLE;
                end
            end
            default: state_next = UART_IDLE;
        endcase
    end

endmodule

// File: rtl/midi_tx.sv
// rtl/midi_tx.sv - MIDI message encoder and 31250-baud UART transmit path
module midi_tx
    import midi_pkg::*;
#(
    parameter int BAUD_DIV       = 1600,
    parameter int RUNNING_STATUS = 1
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       ce,
    input  logic [3:0] channel,
    input  logic [1:0] cmd,
    input  logic [6:0] num,
    input  logic [6:0] vel,
    input  logic       req,
    output logic       ready,
    output logic       done,
    output logic       tx
);

    msg_state_e state;
    msg_state_e state_next;
    logic [1:0] cmd_q;
    logic [3:0] chan_q;
    logic [6:0] num_q;
    logic [6:0] vel_q;
    logic [1:0] byte_idx;
    logic [1:0] sel_idx;
    logic [1:0] last_idx;
    logic [7:0] last_status;
    logic [7:0] status;
    logic [7:0] tx_byte;
    logic       skip;
    logic       start;
    logic       uart_busy;
    logic       accept;

    assign ready  = (state == MSG_IDLE);
    assign accept = req && ready && ce;

    // Byte selection; a status byte equal to the last one sent is skipped by
    // going straight to the first data byte, so LOAD always launches a byte
    always_comb begin
        status   = status_byte(cmd_q, chan_q);
        last_idx = last_byte_idx(cmd_q);
        skip     = (RUNNING_STATUS != 0) && (cmd_q != CMD_RESET)
                   && (byte_idx == 2'd0) && (status == last_status);
        sel_idx  = skip ? 2'd1 : byte_idx;
        case (sel_idx)
            2'd0:    tx_byte = status;
            2'd1:    tx_byte = {1'b0, num_q};
            default: tx_byte = {1'b0, vel_q};
        endcase
    end

    // Message FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= MSG_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Message FSM next state and serializer start strobe
    always_comb begin
        state_next = state;
        start      = 1'b0;
        case (state)
            MSG_IDLE: if (accept) state_next = MSG_LOAD;
            MSG_LOAD: if (ce) begin
                start      = 1'b1;
                state_next = MSG_SEND;
            end
            MSG_SEND: if (ce && !uart_busy) state_next = MSG_NEXT;
            MSG_NEXT: if (ce) state_next = (byte_idx == last_idx) ? MSG_IDLE : MSG_LOAD;
            default:  state_next = MSG_IDLE;
        endcase
    end

    // Request latch, byte index, running-status memory and done pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_q       <= '0;
            chan_q      <= '0;
            num_q       <= '0;
            vel_q       <= '0;
            byte_idx    <= '0;
            last_status <= STATUS_NONE;
            done        <= 1'b0;
        end else if (ce) begin
            done <= (state == MSG_NEXT) && (byte_idx == last_idx);
            case (state)
                MSG_IDLE: if (accept) begin
                    cmd_q    <= cmd;
                    chan_q   <= channel;
                    num_q    <= num;
                    vel_q    <= vel;
                    byte_idx <= 2'd0;
                end
                MSG_LOAD: begin
                    byte_idx <= sel_idx;
                    if (sel_idx == 2'd0) begin
                        last_status <= (cmd_q == CMD_RESET) ? STATUS_NONE : status;
                    end
                end
                MSG_NEXT: if (byte_idx != last_idx) byte_idx <= byte_idx + 2'd1;
                default: ;
            endcase
        end
    end

    midi_uart_tx #(
        .BAUD_DIV(BAUD_DIV)
    ) u_uart (
        .clk   (clk),
        .rst   (rst),
        .ce    (ce),
        .data  (tx_byte),
        .start (start),
        .busy  (uart_busy),
        .tx    (tx)
    );

endmodule
